// File: rtl/uncache_unit.sv
// Uncached load/store engine between MEM1 and the D-side request mux.
// Takes one uncached access at a time, issues a single-beat read or write
// on the cache-style memory interface and reports completion on data_ok.
//
// Handshake semantics: an access is taken when valid is high while data_ok
// is high; rd_req/wr_req stay high with their address/type/strobe/data held
// until the matching rd_rdy/wr_rdy is seen on a clock edge; a read finishes
// on the edge where ret_valid and ret_last are both high. Handshake inputs
// seen outside the matching state have no effect.
module uncache_unit #(
  parameter bit WORD_ONLY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        op,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        rd_req,
  output logic [2:0]  rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data,
  output logic        wr_req,
  output logic [2:0]  wr_type,
  output logic [31:0] wr_addr,
  output logic [3:0]  wr_wstrb,
  output logic [31:0] wr_data,
  input  logic        wr_rdy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] lat_addr;
  logic [2:0]  lat_type;
  logic [3:0]  lat_wstrb;
  logic [31:0] lat_wdata;
  logic [2:0]  acc_type;
  logic [31:0] acc_addr;

  // Bus type and address for the incoming access, narrowed to words if asked.
  always_comb begin
    acc_type = (size == 2'd3) ? 3'b010 : {1'b0, size};
    acc_addr = addr;
    if (WORD_ONLY) begin
      acc_type = 3'b010;
      acc_addr = {addr[31:2], 2'b00};
    end
  end

  // Transaction FSM: accept, hold the request until accepted, collect read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rd_req    <= 1'b0;
      wr_req    <= 1'b0;
      rdata     <= 32'd0;
      lat_addr  <= 32'd0;
      lat_type  <= 3'd0;
      lat_wstrb <= 4'd0;
      lat_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            lat_addr  <= acc_addr;
            lat_type  <= acc_type;
            lat_wstrb <= wstrb;
            lat_wdata <= wdata;
            if (op) begin
              state  <= WR_REQ;
              wr_req <= 1'b1;
            end else begin
              state  <= RD_REQ;
              rd_req <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (rd_rdy) begin
            state  <= RD_WAIT;
            rd_req <= 1'b0;
          end
        end
        RD_WAIT: begin
          // A beat without ret_last is kept but the unit waits for the last one.
          if (ret_valid) begin
            rdata <= ret_data;
            if (ret_last) state <= IDLE;
          end
        end
        WR_REQ: begin
          if (wr_rdy) begin
            state  <= IDLE;
            wr_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_ok   = (state == IDLE);
  assign dbg_state = state;
  assign rd_addr   = lat_addr;
  assign rd_type   = lat_type;
  assign wr_addr   = lat_addr;
  assign wr_type   = lat_type;
  assign wr_wstrb  = lat_wstrb;
  assign wr_data   = lat_wdata;

endmodule

// File: tb/tb_uncache_unit.sv
// Bench for uncache_unit: two instances (pass-through sizes and word-only)
// share one stimulus; expectations come from a transaction-level model.
module tb_uncache_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        op = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [1:0]  size = 2'd0;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic        rd_rdy = 1'b0;
  logic        ret_valid = 1'b0;
  logic        ret_last = 1'b0;
  logic [31:0] ret_data = 32'd0;
  logic        wr_rdy = 1'b0;

  logic        data_ok_0, rd_req_0, wr_req_0, data_ok_1, rd_req_1, wr_req_1;
  logic [31:0] rdata_0, rd_addr_0, wr_addr_0, wr_data_0;
  logic [31:0] rdata_1, rd_addr_1, wr_addr_1, wr_data_1;
  logic [2:0]  rd_type_0, wr_type_0, rd_type_1, wr_type_1;
  logic [3:0]  wr_wstrb_0, wr_wstrb_1;
  logic [1:0]  dbg_state_0, dbg_state_1;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rdata = 32'd0;

  uncache_unit #(.WORD_ONLY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .valid(valid), .op(op), .addr(addr), .size(size),
    .wstrb(wstrb), .wdata(wdata), .data_ok(data_ok_0), .rdata(rdata_0),
    .rd_req(rd_req_0), .rd_type(rd_type_0), .rd_addr(rd_addr_0), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req_0), .wr_type(wr_type_0), .wr_addr(wr_addr_0),
    .wr_wstrb(wr_wstrb_0), .wr_data(wr_data_0), .wr_rdy(wr_rdy),
    .dbg_state(dbg_state_0)
  );

  uncache_unit #(.WORD_ONLY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .valid(valid), .op(op), .addr(addr), .size(size),
    .wstrb(wstrb), .wdata(wdata), .data_ok(data_ok_1), .rdata(rdata_1),
    .rd_req(rd_req_1), .rd_type(rd_type_1), .rd_addr(rd_addr_1), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req_1), .wr_type(wr_type_1), .wr_addr(wr_addr_1),
    .wr_wstrb(wr_wstrb_1), .wr_data(wr_data_1), .wr_rdy(wr_rdy),
    .dbg_state(dbg_state_1)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model of the bus fields for each configuration.
  function automatic logic [2:0] model_type(input logic [1:0] sz, input bit word_only);
    if (word_only) return 3'd2;
    return (sz == 2'd3) ? 3'd2 : {1'b0, sz};
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] a, input bit word_only);
    return word_only ? (a & 32'hffff_fffc) : a;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " data_ok0"}, {31'd0, data_ok_0}, 32'd1);
    check({tag, " data_ok1"}, {31'd0, data_ok_1}, 32'd1);
    check({tag, " reqs0"}, {30'd0, rd_req_0, wr_req_0}, 32'd0);
    check({tag, " reqs1"}, {30'd0, rd_req_1, wr_req_1}, 32'd0);
    check({tag, " rdata0"}, rdata_0, exp_rdata);
    check({tag, " rdata1"}, rdata_1, exp_rdata);
  endtask

  task automatic check_rd_hold(input string tag, input logic [31:0] a, input logic [1:0] sz);
    check({tag, " rd_req"}, {30'd0, rd_req_0, rd_req_1}, 32'd3);
    check({tag, " wr_req"}, {30'd0, wr_req_0, wr_req_1}, 32'd0);
    check({tag, " data_ok"}, {30'd0, data_ok_0, data_ok_1}, 32'd0);
    check({tag, " rd_addr0"}, rd_addr_0, model_addr(a, 1'b0));
    check({tag, " rd_addr1"}, rd_addr_1, model_addr(a, 1'b1));
    check({tag, " rd_type0"}, {29'd0, rd_type_0}, {29'd0, model_type(sz, 1'b0)});
    check({tag, " rd_type1"}, {29'd0, rd_type_1}, {29'd0, model_type(sz, 1'b1)});
  endtask

  // Load: accept, stall the request, wait for data (optionally with a stray
  // non-last beat and an ignored second valid), then complete.
  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input int stall,
                         input int lag, input bit junk_beat, input bit busy_valid,
                         input logic [31:0] data, input bit reset_in_wait);
    logic [31:0] junk;
    exp_q.push_back(data);
    valid = 1'b1; op = 1'b0; addr = a; size = sz;
    step();
    valid = 1'b0; addr = $urandom; size = 2'($urandom);
    check_rd_hold("ld accept", a, sz);
    for (int i = 0; i < stall; i++) begin
      ret_valid = 1'b1; ret_last = 1'b1; ret_data = $urandom;  // ignored outside RD_WAIT
      step();
      check_rd_hold("ld stall", a, sz);
      check("ld stall rdata", rdata_0, exp_rdata);
    end
    ret_valid = 1'b0; ret_last = 1'b0;
    rd_rdy = 1'b1;
    step();
    rd_rdy = 1'b0;
    check("ld wait rd_req", {30'd0, rd_req_0, rd_req_1}, 32'd0);
    check("ld wait data_ok", {30'd0, data_ok_0, data_ok_1}, 32'd0);
    for (int i = 0; i < lag; i++) begin
      if (busy_valid) begin valid = 1'b1; op = 1'($urandom); rd_rdy = 1'b1; wr_rdy = 1'b1; end
      step();
      check("busy rd_req", {30'd0, rd_req_0, rd_req_1}, 32'd0);
      check("busy wr_req", {30'd0, wr_req_0, wr_req_1}, 32'd0);
      check("busy data_ok", {31'd0, data_ok_0}, 32'd0);
    end
    valid = 1'b0; rd_rdy = 1'b0; wr_rdy = 1'b0;
    if (junk_beat) begin
      junk = $urandom;
      ret_valid = 1'b1; ret_last = 1'b0; ret_data = junk;
      step();
      exp_rdata = junk;
      check("junk beat data_ok", {31'd0, data_ok_0}, 32'd0);
      check("junk beat rdata0", rdata_0, exp_rdata);
      check("junk beat rdata1", rdata_1, exp_rdata);
    end
    if (reset_in_wait) begin
      ret_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_rdata = 32'd0;
      void'(exp_q.pop_back());
      check_idle("rst in wait");
      ret_valid = 1'b1; ret_last = 1'b1; ret_data = data;
      step();
      ret_valid = 1'b0; ret_last = 1'b0;
      check_idle("late beat");
      return;
    end
    ret_valid = 1'b1; ret_last = 1'b1; ret_data = data;
    step();
    ret_valid = 1'b0; ret_last = 1'b0; ret_data = $urandom;
    exp_rdata = exp_q.pop_front();
    check_idle("ld done");
  endtask

  // Store: accept, hold the request through a stall, complete on wr_rdy.
  task automatic do_store(input logic [31:0] a, input logic [1:0] sz, input logic [3:0] be,
                          input logic [31:0] d, input int stall);
    valid = 1'b1; op = 1'b1; addr = a; size = sz; wstrb = be; wdata = d;
    step();
    valid = 1'b0; addr = $urandom; wstrb = 4'($urandom); wdata = $urandom;
    for (int i = 0; i <= stall; i++) begin
      check("st wr_req", {30'd0, wr_req_0, wr_req_1}, 32'd3);
      check("st rd_req", {30'd0, rd_req_0, rd_req_1}, 32'd0);
      check("st data_ok", {30'd0, data_ok_0, data_ok_1}, 32'd0);
      check("st wr_addr0", wr_addr_0, model_addr(a, 1'b0));
      check("st wr_addr1", wr_addr_1, model_addr(a, 1'b1));
      check("st wr_type0", {29'd0, wr_type_0}, {29'd0, model_type(sz, 1'b0)});
      check("st wr_type1", {29'd0, wr_type_1}, {29'd0, model_type(sz, 1'b1)});
      check("st wstrb", {24'd0, wr_wstrb_0, wr_wstrb_1}, {24'd0, be, be});
      check("st wdata0", wr_data_0, d);
      check("st wdata1", wr_data_1, d);
      if (i < stall) begin
        rd_rdy = 1'b1;  // wrong-side ready must not end a write
        ret_valid = 1'b1; ret_last = 1'b1; ret_data = $urandom;
        step();
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
      end
    end
    wr_rdy = 1'b1;
    step();
    wr_rdy = 1'b0;
    check_idle("st done");
  endtask

  initial begin
    // Reset and idle
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_idle("reset");
    step();
    check_idle("idle");

    // Minimum-latency word load
    do_load(32'h1faf_f024, 2'd2, 0, 0, 1'b0, 1'b0, 32'hdead_beef, 1'b0);
    // Byte store stalled for five cycles
    do_store(32'h1faf_f001, 2'd0, 4'b0010, 32'h0000_5a00, 5);
    // Second valid during RD_WAIT is ignored
    do_load(32'h1faf_f010, 2'd2, 1, 3, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    // Reset during RD_WAIT followed by a late beat
    do_load(32'h1faf_f020, 2'd2, 0, 1, 1'b1, 1'b0, 32'h0bad_f00d, 1'b1);
    // Half-word load: word-only instance aligns and widens
    do_load(32'h1faf_f006, 2'd1, 2, 1, 1'b0, 1'b0, 32'hcafe_0001, 1'b0);
    // size 3 behaves as word
    do_load(32'h1faf_f033, 2'd3, 0, 0, 1'b0, 1'b0, 32'h5555_aaaa, 1'b0);

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(1, 0) == 1)
        do_store({12'h1fa, 20'($urandom)}, 2'($urandom), 4'($urandom), $urandom,
                 $urandom_range(3, 0));
      else
        do_load({12'h1fa, 20'($urandom)}, 2'($urandom), $urandom_range(3, 0),
                $urandom_range(3, 0), 1'($urandom), 1'($urandom), $urandom,
                ($urandom_range(7, 0) == 0));
      repeat ($urandom_range(2, 0)) begin
        step();
        check_idle("gap");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
